// File: rtl/rr_arbiter3_pkg.sv
// Shared types and constants for the 3-client round-robin arbiter.
package rr_arbiter3_pkg;

  localparam int N_CLIENTS = 3;

  // 2-bit FSM encoding; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Converts a client index to a one-hot grant vector (all-zero for index 3).
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] vec;
    case (idx)
      2'd0:    vec = 3'b001;
      2'd1:    vec = 3'b010;
      2'd2:    vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: searches last+1, last+2, last+3 (mod 3).
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       valid
);

  // Select the first requesting client after the previous owner.
  always_comb begin
    pick  = 2'd0;
    valid = |req;
    case (last)
      2'd0: begin
        if (req[1])      pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else             pick = 2'd0;
      end
      2'd1: begin
        if (req[2])      pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else             pick = 2'd1;
      end
      default: begin
        if (req[0])      pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else             pick = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/rr_arbiter3.sv
// Three-client round-robin arbiter with registered one-hot grant, hold
// timeout, and a mandatory dead cycle between successive owners.
module rr_arbiter3
  import rr_arbiter3_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 1000,
  parameter int unsigned CW       = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       any_req,
  output logic       expired
);

  localparam bit            TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  state_t        state_r, state_s;
  logic [2:0]    gnt_r, gnt_s;
  logic [1:0]    gnt_id_r, gnt_id_s;
  logic          busy_r, busy_s;
  logic          expired_r, expired_s;
  logic [CW-1:0] hold_cnt_r, hold_cnt_s;
  logic [1:0]    last_r, last_s;
  logic [1:0]    pick_s;
  logic          pick_valid_s;
  logic          owner_req_s;

  rr_pick3 u_pick (
    .req   (req),
    .last  (last_r),
    .pick  (pick_s),
    .valid (pick_valid_s)
  );

  assign any_req     = |req;
  // Owner still requesting; gnt_r is one-hot of gnt_id_r while granting.
  assign owner_req_s = |(req & gnt_r);

  // Next-state and next-output logic for the IDLE/GRANT/GAP sequence.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    gnt_id_s   = gnt_id_r;
    busy_s     = busy_r;
    expired_s  = 1'b0;
    hold_cnt_s = hold_cnt_r;
    last_s     = last_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          gnt_s      = onehot3(pick_s);
          gnt_id_s   = pick_s;
          busy_s     = 1'b1;
          last_s     = pick_s;
          hold_cnt_s = '0;
          state_s    = ST_GRANT;
        end else begin
          gnt_s   = 3'b000;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_req_s) begin
          // Normal release wins over a coincident timeout.
          gnt_s   = 3'b000;
          busy_s  = 1'b0;
          state_s = ST_GAP;
        end else if (TIMEOUT_EN && (hold_cnt_r == HOLD_LAST)) begin
          gnt_s     = 3'b000;
          busy_s    = 1'b0;
          expired_s = 1'b1;
          state_s   = ST_GAP;
        end else begin
          hold_cnt_s = hold_cnt_r + CW'(1);
        end
      end
      ST_GAP: begin
        gnt_s   = 3'b000;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        gnt_s      = 3'b000;
        busy_s     = 1'b0;
        hold_cnt_s = '0;
        state_s    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last resets to 2 so client 0 wins first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      gnt_r      <= 3'b000;
      gnt_id_r   <= 2'd0;
      busy_r     <= 1'b0;
      expired_r  <= 1'b0;
      hold_cnt_r <= '0;
      last_r     <= 2'd2;
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      gnt_id_r   <= gnt_id_s;
      busy_r     <= busy_s;
      expired_r  <= expired_s;
      hold_cnt_r <= hold_cnt_s;
      last_r     <= last_s;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_id  = gnt_id_r;
  assign busy    = busy_r;
  assign expired = expired_r;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Directed bench for rr_arbiter3: instance A uses MAX_HOLD=4, instance B
// uses MAX_HOLD=3 for the coincident release/timeout case.
module tb_rr_arbiter3;

  logic       clk;
  logic       rstn;
  logic [2:0] req_a, req_b;
  logic [2:0] gnt_a, gnt_b;
  logic [1:0] gnt_id_a, gnt_id_b;
  logic       busy_a, busy_b;
  logic       any_req_a, any_req_b;
  logic       expired_a, expired_b;

  int checks = 0;
  int errors = 0;

  rr_arbiter3 #(.MAX_HOLD(4), .CW(16)) u_a (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req_a),
    .gnt     (gnt_a),
    .gnt_id  (gnt_id_a),
    .busy    (busy_a),
    .any_req (any_req_a),
    .expired (expired_a)
  );

  rr_arbiter3 #(.MAX_HOLD(3), .CW(16)) u_b (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req_b),
    .gnt     (gnt_b),
    .gnt_id  (gnt_id_b),
    .busy    (busy_b),
    .any_req (any_req_b),
    .expired (expired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the grant vector of instance A over n consecutive cycles.
  task automatic expect_a(input string tag, input logic [2:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, {29'd0, gnt_a}, {29'd0, g});
    end
  endtask

  initial begin
    // Reset and first grant
    rstn  = 1'b0;
    req_a = 3'b111;
    req_b = 3'b000;
    #3;
    check("rst_gnt",     {29'd0, gnt_a},     32'd0);
    check("rst_gnt_id",  {30'd0, gnt_id_a},  32'd0);
    check("rst_busy",    {31'd0, busy_a},    32'd0);
    check("rst_expired", {31'd0, expired_a}, 32'd0);
    check("rst_any_req", {31'd0, any_req_a}, 32'd1);
    check("rst_any_req_b", {31'd0, any_req_b}, 32'd0);
    #20;
    rstn = 1'b1;
    tick();
    check("first_gnt",     {29'd0, gnt_a},     32'd1);
    check("first_gnt_id",  {30'd0, gnt_id_a},  32'd0);
    check("first_busy",    {31'd0, busy_a},    32'd1);
    check("first_expired", {31'd0, expired_a}, 32'd0);

    // Release and rotation 0 -> 1 -> 2 -> 0
    req_a = 3'b110;
    expect_a("rel0_gap", 3'b000, 1);
    check("rel0_busy", {31'd0, busy_a}, 32'd0);
    req_a = 3'b111;
    expect_a("rel0_idle", 3'b000, 1);
    expect_a("rot_to1", 3'b010, 1);
    check("rot_to1_id", {30'd0, gnt_id_a}, 32'd1);
    req_a = 3'b101;
    expect_a("rel1_gap", 3'b000, 1);
    req_a = 3'b111;
    expect_a("rel1_idle", 3'b000, 1);
    expect_a("rot_to2", 3'b100, 1);
    check("rot_to2_id", {30'd0, gnt_id_a}, 32'd2);
    req_a = 3'b011;
    expect_a("rel2_gap", 3'b000, 1);
    req_a = 3'b111;
    expect_a("rel2_idle", 3'b000, 1);
    expect_a("rot_wrap0", 3'b001, 1);
    req_a = 3'b000;
    check("any_req_low", {31'd0, any_req_a}, 32'd0);
    expect_a("drain", 3'b000, 3);
    check("drain_id_hold", {30'd0, gnt_id_a}, 32'd0);

    // Timeout with a single persistent requester (last=0, client 0 still wins)
    req_a = 3'b001;
    expect_a("to_hold", 3'b001, 4);
    check("to_noexp_last", {31'd0, expired_a}, 32'd0);
    expect_a("to_gap", 3'b000, 1);
    check("to_expired", {31'd0, expired_a}, 32'd1);
    check("to_busy", {31'd0, busy_a}, 32'd0);
    expect_a("to_idle", 3'b000, 1);
    check("to_exp_pulse", {31'd0, expired_a}, 32'd0);
    expect_a("to_regrant", 3'b001, 1);
    req_a = 3'b000;
    expect_a("to_drain", 3'b000, 2);

    // Idle reset to restore last=2, then fairness after timeout
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
    req_a = 3'b011;
    expect_a("fair_c0", 3'b001, 4);
    expect_a("fair_gap0", 3'b000, 1);
    check("fair_exp0", {31'd0, expired_a}, 32'd1);
    expect_a("fair_idle0", 3'b000, 1);
    expect_a("fair_c1", 3'b010, 4);
    expect_a("fair_gap1", 3'b000, 1);
    check("fair_exp1", {31'd0, expired_a}, 32'd1);
    expect_a("fair_idle1", 3'b000, 1);
    expect_a("fair_back0", 3'b001, 1);

    // Move ownership to client 1, then reset asynchronously mid-grant
    req_a = 3'b010;
    expect_a("mv_gap", 3'b000, 2);
    expect_a("mv_c1", 3'b010, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_gnt",    {29'd0, gnt_a},    32'd0);
    check("arst_busy",   {31'd0, busy_a},   32'd0);
    check("arst_gnt_id", {30'd0, gnt_id_a}, 32'd0);
    check("arst_any_req", {31'd0, any_req_a}, 32'd1);
    #1 rstn = 1'b1;
    tick();
    check("arst_regrant",    {29'd0, gnt_a},    32'd2);
    check("arst_regrant_id", {30'd0, gnt_id_a}, 32'd1);
    req_a = 3'b000;

    // Instance B: release on the same edge the hold counter would expire
    req_b = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_hold", {29'd0, gnt_b}, 32'd1);
    end
    req_b = 3'b000;
    tick();
    check("b_same_gnt",     {29'd0, gnt_b},     32'd0);
    check("b_same_expired", {31'd0, expired_b}, 32'd0);
    tick();
    check("b_same_expired2", {31'd0, expired_b}, 32'd0);
    tick();
    // Instance B: genuine timeout after exactly 3 grant cycles
    req_b = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_to_hold", {29'd0, gnt_b}, 32'd1);
    end
    tick();
    check("b_to_gnt",     {29'd0, gnt_b},     32'd0);
    check("b_to_expired", {31'd0, expired_b}, 32'd1);
    req_b = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
